// File: rtl/fps_mask_idx_gen.sv
// fps_mask_idx_gen: turns newly set FPS mask bits into GLB index writes.
// Optional MSKIDX_ERRCHK_EN enables the sticky protocol-error flag.
module fps_mask_idx_gen #(
  parameter int IDX_WIDTH  = 10,
  parameter int CHUNK      = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    CCUCTR_Rst,
  input  logic                    CCUCTR_CfgVld,
  output logic                    MSKCCU_CfgRdy,
  input  logic [IDX_WIDTH-1:0]    CCUCTR_CfgNop,
  input  logic [ADDR_WIDTH-1:0]   CCUCTR_CfgBase,
  input  logic [2**IDX_WIDTH-1:0] FPSPSS_Mask,
  input  logic                    FPSPSS_MaskVld,
  output logic                    PSSFPS_MaskRdy,
  output logic [ADDR_WIDTH-1:0]   MSKGLB_IdxAddr,
  output logic [IDX_WIDTH-1:0]    MSKGLB_Idx,
  output logic                    MSKGLB_IdxVld,
  input  logic                    GLBMSK_IdxRdy,
  output logic                    MSKCCU_Done,
  output logic                    MSKCCU_Err
);
  localparam int MW   = 2**IDX_WIDTH;
  localparam int NCH  = MW / CHUNK;
  localparam int PTRW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW   = (CHUNK > 1) ? $clog2(CHUNK) : 1;
  localparam logic [PTRW-1:0] LAST = PTRW'(NCH - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_WAIT, S_SCAN, S_DONE
  } state_t;

  state_t state, nxt;

  logic [MW-1:0]         prevQ, newQ;
  logic [PTRW-1:0]       ptrQ;
  logic [IDX_WIDTH-1:0]  cntQ, nopQ;
  logic [ADDR_WIDTH-1:0] baseQ;

  logic [CHUNK-1:0]      cur;
  logic [CW-1:0]         pos;
  logic [IDX_WIDTH-1:0]  idx;
  logic                  curNz, full;
  logic                  emit, drop, fire, accept;

  assign cur    = newQ[int'(ptrQ)*CHUNK +: CHUNK];
  assign curNz  = |cur;
  assign full   = (cntQ == nopQ);
  assign emit   = (state == S_SCAN) && curNz && !full;
  assign drop   = (state == S_SCAN) && curNz && full;
  assign fire   = emit && GLBMSK_IdxRdy;
  assign accept = (state == S_WAIT) && FPSPSS_MaskVld;
  assign idx    = IDX_WIDTH'(ptrQ) * IDX_WIDTH'(CHUNK)
                + IDX_WIDTH'(pos);

  // lowest set bit of the current chunk
  always_comb begin
    pos = '0;
    for (int i = CHUNK-1; i >= 0; i--)
      if (cur[i]) pos = CW'(i);
  end

  assign MSKGLB_IdxVld  = emit;
  assign MSKGLB_Idx     = emit ? idx : '0;
  assign MSKGLB_IdxAddr = emit ? baseQ + ADDR_WIDTH'(cntQ) : '0;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  // next state and handshake outputs
  always_comb begin
    nxt            = state;
    MSKCCU_CfgRdy  = 1'b0;
    PSSFPS_MaskRdy = 1'b0;
    MSKCCU_Done    = 1'b0;
    unique case (state)
      S_IDLE: begin
        MSKCCU_CfgRdy = 1'b1;
        if (CCUCTR_CfgVld)
          nxt = (CCUCTR_CfgNop == '0) ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        PSSFPS_MaskRdy = 1'b1;
        if (FPSPSS_MaskVld) nxt = S_SCAN;
      end
      S_SCAN: begin
        if (!curNz && ptrQ == LAST)
          nxt = full ? S_DONE : S_WAIT;
      end
      S_DONE: begin
        MSKCCU_Done = 1'b1;
        nxt         = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
    if (CCUCTR_Rst) nxt = S_IDLE;
  end

  // mask history, scan pointer and emit counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prevQ <= '0;
      newQ  <= '0;
      ptrQ  <= '0;
      cntQ  <= '0;
      nopQ  <= '0;
      baseQ <= '0;
    end else if (CCUCTR_Rst) begin
      prevQ <= '0;
      newQ  <= '0;
      ptrQ  <= '0;
      cntQ  <= '0;
      nopQ  <= '0;
      baseQ <= '0;
    end else begin
      if (state == S_IDLE && CCUCTR_CfgVld) begin
        nopQ  <= CCUCTR_CfgNop;
        baseQ <= CCUCTR_CfgBase;
        cntQ  <= '0;
        prevQ <= '0;
        newQ  <= '0;
        ptrQ  <= '0;
      end
      if (accept) begin
        newQ  <= FPSPSS_Mask & ~prevQ;
        prevQ <= FPSPSS_Mask;
        ptrQ  <= '0;
      end
      if (fire) begin
        newQ[idx] <= 1'b0;
        cntQ      <= cntQ + 1'b1;
      end else if (drop) begin
        newQ[idx] <= 1'b0;
      end else if (state == S_SCAN && !curNz
                   && ptrQ != LAST) begin
        ptrQ <= ptrQ + 1'b1;
      end
    end
  end

`ifdef MSKIDX_ERRCHK_EN
  logic errQ;

  // sticky flag: empty update, lost prev bit, or discarded find
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      errQ <= 1'b0;
    else if (CCUCTR_Rst)
      errQ <= 1'b0;
    else if (accept &&
             (((FPSPSS_Mask & ~prevQ) == '0) ||
              ((FPSPSS_Mask & prevQ) != prevQ)))
      errQ <= 1'b1;
    else if (drop)
      errQ <= 1'b1;
  end

  assign MSKCCU_Err = errQ;
`else
  assign MSKCCU_Err = 1'b0;
`endif

endmodule

// File: tb/tb_fps_mask_idx_gen.sv
// Bench for fps_mask_idx_gen: write-stream model plus
// directed timing checks.
module tb_fps_mask_idx_gen;
  localparam int IW = 10;
  localparam int AW = 12;
  localparam int MW = 1024;
`ifdef MSKIDX_ERRCHK_EN
  localparam int ERRON = 1;
`else
  localparam int ERRON = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ccuRst = 1'b0;
  logic          cfgVld = 1'b0;
  logic          cfgRdy;
  logic [IW-1:0] cfgNop = '0;
  logic [AW-1:0] cfgBase = '0;
  logic [MW-1:0] mask = '0;
  logic          maskVld = 1'b0;
  logic          maskRdy;
  logic [AW-1:0] idxAddr;
  logic [IW-1:0] idx;
  logic          idxVld;
  logic          idxRdy = 1'b1;
  logic          done;
  logic          err;

  int nTests = 0;
  int nFail  = 0;

  int mNop, mCnt, mBase;
  logic [MW-1:0] mPrev = '0;
  int expIdx[$];
  int expAddr[$];
  int wrIdx[$];
  int wrAddr[$];
  int expDone = 0;
  int doneCnt = 0;

  fps_mask_idx_gen dut (
    .clk(clk),
    .rst(rst),
    .CCUCTR_Rst(ccuRst),
    .CCUCTR_CfgVld(cfgVld),
    .MSKCCU_CfgRdy(cfgRdy),
    .CCUCTR_CfgNop(cfgNop),
    .CCUCTR_CfgBase(cfgBase),
    .FPSPSS_Mask(mask),
    .FPSPSS_MaskVld(maskVld),
    .PSSFPS_MaskRdy(maskRdy),
    .MSKGLB_IdxAddr(idxAddr),
    .MSKGLB_Idx(idx),
    .MSKGLB_IdxVld(idxVld),
    .GLBMSK_IdxRdy(idxRdy),
    .MSKCCU_Done(done),
    .MSKCCU_Err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act,
                     input int exp);
    nTests++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic bad(input string nm);
    nTests++;
    nFail++;
    $display("FAIL %s: timed out", nm);
  endtask

  function automatic logic [MW-1:0] bits3(input int a,
                                          input int b,
                                          input int c);
    logic [MW-1:0] m;
    m = '0;
    if (a >= 0) m[a] = 1'b1;
    if (b >= 0) m[b] = 1'b1;
    if (c >= 0) m[c] = 1'b1;
    return m;
  endfunction

  // scoreboard: every accepted write must match the model
  always @(negedge clk) begin
    if (!rst) begin
      if (done) doneCnt++;
      if (idxVld && idxRdy) begin
        wrIdx.push_back(int'(idx));
        wrAddr.push_back(int'(idxAddr));
        if (expIdx.size() == 0) begin
          nTests++;
          nFail++;
          $display("FAIL extra write: idx %0d addr %0d",
                   idx, idxAddr);
        end else begin
          chk("write idx", int'(idx), expIdx.pop_front());
          chk("write addr", int'(idxAddr),
              expAddr.pop_front());
        end
      end
    end
  end

  task automatic cfg(input int nop, input int base);
    int k;
    k = 0;
    @(negedge clk);
    while (!cfgRdy && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!cfgRdy) bad("cfg ready");
    @(posedge clk);
    #1;
    cfgNop  = IW'(nop);
    cfgBase = AW'(base);
    cfgVld  = 1'b1;
    @(posedge clk);
    #1 cfgVld = 1'b0;
    mNop  = nop;
    mBase = base;
    mCnt  = 0;
    mPrev = '0;
    if (nop == 0) expDone++;
  endtask

  task automatic sendMask(input logic [MW-1:0] m);
    int k;
    logic [MW-1:0] nb;
    mask    = m;
    maskVld = 1'b1;
    k = 0;
    @(negedge clk);
    while (!maskRdy && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!maskRdy) begin
      bad("mask ready");
      maskVld = 1'b0;
      return;
    end
    @(posedge clk);
    #1 maskVld = 1'b0;
    nb = m & ~mPrev;
    for (int i = 0; i < MW; i++) begin
      if (nb[i] && mCnt < mNop) begin
        expIdx.push_back(i);
        expAddr.push_back((mBase + mCnt) % 4096);
        mCnt++;
      end
    end
    mPrev = m;
    if (mCnt == mNop) expDone++;
  endtask

  task automatic ccuClear();
    @(posedge clk);
    #1 ccuRst = 1'b1;
    @(posedge clk);
    #1 ccuRst = 1'b0;
    expIdx.delete();
    expAddr.delete();
    mCnt  = 0;
    mPrev = '0;
  endtask

  task automatic waitDone(input string nm);
    int k;
    k = 0;
    @(negedge clk);
    while (!done && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk(nm, int'(done), 1);
  endtask

  task automatic waitVld(input string nm);
    int k;
    k = 0;
    @(negedge clk);
    while (!idxVld && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk(nm, int'(idxVld), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation ran too long");
    $fatal(1);
  end

  initial begin
    int vA[37];
    int iA[37];
    int dA[37];

    // reset values
    @(negedge clk);
    chk("rst MaskRdy", int'(maskRdy), 0);
    chk("rst IdxVld", int'(idxVld), 0);
    chk("rst Done", int'(done), 0);
    chk("rst Err", int'(err), 0);
    chk("rst IdxAddr", int'(idxAddr), 0);
    chk("rst Idx", int'(idx), 0);
    chk("rst CfgRdy", int'(cfgRdy), 1);
    @(posedge clk);
    #1 rst = 1'b0;

    // incremental masks, three writes
    cfg(3, 'h100);
    sendMask(bits3(5, -1, -1));
    sendMask(bits3(5, 70, -1));
    sendMask(bits3(5, 70, 1023));
    waitDone("t1 done");
    @(negedge clk);
    chk("t1 CfgRdy after", int'(cfgRdy), 1);
    chk("t1 Done single", int'(done), 0);
    chk("t1 nwr", wrIdx.size(), 3);
    chk("t1 w0 idx", wrIdx[0], 5);
    chk("t1 w0 addr", wrAddr[0], 'h100);
    chk("t1 w1 idx", wrIdx[1], 70);
    chk("t1 w1 addr", wrAddr[1], 'h101);
    chk("t1 w2 idx", wrIdx[2], 1023);
    chk("t1 w2 addr", wrAddr[2], 'h102);

    // three bits in chunk 0: back-to-back then full scan
    cfg(3, 0);
    sendMask(bits3(3, 4, 31));
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      vA[k] = int'(idxVld);
      iA[k] = int'(idx);
      dA[k] = int'(done);
    end
    chk("t2 vld t+1", vA[1], 1);
    chk("t2 idx t+1", iA[1], 3);
    chk("t2 vld t+2", vA[2], 1);
    chk("t2 idx t+2", iA[2], 4);
    chk("t2 vld t+3", vA[3], 1);
    chk("t2 idx t+3", iA[3], 31);
    chk("t2 vld t+4", vA[4], 0);
    chk("t2 done t+35", dA[35], 0);
    chk("t2 done t+36", dA[36], 1);

    // write stall on idx 70
    cfg(2, 'h20);
    idxRdy = 1'b0;
    sendMask(bits3(70, 100, -1));
    waitVld("t3 vld");
    for (int s = 0; s < 5; s++) begin
      chk("t3 stall vld", int'(idxVld), 1);
      chk("t3 stall idx", int'(idx), 70);
      chk("t3 stall addr", int'(idxAddr), 'h20);
      if (s < 4) begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    @(posedge clk);
    #1 idxRdy = 1'b1;
    waitDone("t3 done");

    // Nop zero goes straight to done
    cfg(0, 'h10);
    @(negedge clk);
    chk("t4 done", int'(done), 1);
    chk("t4 maskrdy", int'(maskRdy), 0);
    @(negedge clk);
    chk("t4 cfgrdy", int'(cfgRdy), 1);
    chk("t4 maskrdy2", int'(maskRdy), 0);

    // clear mid-scan, then full re-emit
    cfg(5, 'h40);
    idxRdy = 1'b0;
    sendMask(bits3(40, 600, -1));
    waitVld("t5 vld");
    chk("t5 idx", int'(idx), 40);
    ccuClear();
    @(negedge clk);
    chk("t5 vld drop", int'(idxVld), 0);
    chk("t5 idle", int'(cfgRdy), 1);
    idxRdy = 1'b1;
    cfg(2, 'h80);
    sendMask(bits3(40, 600, -1));
    waitDone("t5 done");

    // error cases
    cfg(3, 0);
    sendMask(bits3(9, -1, -1));
    sendMask(bits3(9, -1, -1));
    @(negedge clk);
    chk("t6 repeat err", int'(err), ERRON);
    ccuClear();
    @(negedge clk);
    chk("t6 clr err", int'(err), 0);
    cfg(3, 0);
    sendMask(bits3(5, -1, -1));
    sendMask(bits3(6, -1, -1));
    @(negedge clk);
    chk("t6 drop bit err", int'(err), ERRON);
    repeat (40) @(posedge clk);
    ccuClear();
    @(negedge clk);
    chk("t6 clr err2", int'(err), 0);
    cfg(1, 0);
    sendMask(bits3(1, 2, -1));
    waitDone("t6 done");
    chk("t6 discard err", int'(err), ERRON);

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("left expected", expIdx.size(), 0);
    chk("done count", doneCnt, expDone);

    $display("[TB] %0d tests run, %0d failed",
             nTests, nFail);
    $finish;
  end
endmodule
